// File: rtl/demux_4_pipe_pkg.sv
// demux_4_pipe_pkg
//   Shared definitions for the 1-to-4 result demultiplexer.
//   SEL_1..SEL_4 use the same op encoding as the datapath 4-way selectors,
//   so a select value means the same thing everywhere in the pipeline.
package demux_4_pipe_pkg;

  localparam logic [1:0] SEL_1 = 2'b00;
  localparam logic [1:0] SEL_2 = 2'b01;
  localparam logic [1:0] SEL_3 = 2'b10;
  localparam logic [1:0] SEL_4 = 2'b11;

  localparam int unsigned NUM_PORTS  = 4;
  localparam int unsigned FIFO_DEPTH = 2;

  // One-hot port mask for a select value.
  function automatic logic [NUM_PORTS-1:0] sel_onehot(input logic [1:0] sel);
    logic [NUM_PORTS-1:0] mask;
    mask = '0;
    case (sel)
      SEL_1:   mask = 4'b0001;
      SEL_2:   mask = 4'b0010;
      SEL_3:   mask = 4'b0100;
      default: mask = 4'b1000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/demux_4_pipe_fifo_2.sv
// fifo_2
//   Two-entry synchronous FIFO used as the per-port buffer.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     push, din  : write request and data (ignored when full)
//     pop        : remove head word (ignored when empty)
//     dout       : head word, all-zero when empty
//     full/empty : occupancy flags derived from the registered count
module fifo_2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Guards keep state consistent even if a caller ignores the flags.
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/demux_4_pipe.sv
// demux_4_pipe
//   Registered 1-to-4 demultiplexer with a 2-entry FIFO per output port.
//   Handshake rule (both sides): a transfer happens in a cycle exactly when
//   valid and ready are both high at the rising edge; a valid producer holds
//   its data until it is taken. in_ready depends only on op and registered
//   FIFO counts, never on out_ready.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     in_valid/in_ready   : producer handshake
//     op                  : destination port (SEL_1..SEL_4 -> port 1..4)
//     in_data             : payload
//     out_valid/out_ready : per-port consumer handshake, bit i-1 = port i
//     out_1..out_4        : head word of each port, zero when empty
module demux_4_pipe
  import demux_4_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_1,
  output logic [WIDTH-1:0] out_2,
  output logic [WIDTH-1:0] out_3,
  output logic [WIDTH-1:0] out_4
);

  logic [3:0]       push_en;
  logic [3:0]       pop_en;
  logic [3:0]       full;
  logic [3:0]       empty;
  logic [WIDTH-1:0] dout [4];
  logic             accept;

  always_comb begin
    in_ready = 1'b1;
    case (op)
      SEL_1:   in_ready = ~full[0];
      SEL_2:   in_ready = ~full[1];
      SEL_3:   in_ready = ~full[2];
      default: in_ready = ~full[3];
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign push_en   = accept ? sel_onehot(op) : 4'b0000;
  assign out_valid = ~empty;
  assign pop_en    = out_valid & out_ready;

  for (genvar i = 0; i < 4; i++) begin : g_port
    fifo_2 #(.WIDTH(WIDTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_en[i]),
      .din   (in_data),
      .pop   (pop_en[i]),
      .dout  (dout[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  assign out_1 = dout[0];
  assign out_2 = dout[1];
  assign out_3 = dout[2];
  assign out_4 = dout[3];

endmodule

// File: tb/tb_demux_4_pipe.sv
module tb_demux_4_pipe;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] in_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_1, out_2, out_3, out_4;

  int total = 0;
  int bad   = 0;

  // Reference model: one queue of pending words per port.
  logic [W-1:0] exp_q [4][$];

  demux_4_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_1     (out_1),
    .out_2     (out_2),
    .out_3     (out_3),
    .out_4     (out_4)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_head(input int p);
    return (exp_q[p].size() > 0) ? exp_q[p][0] : '0;
  endfunction

  // Compare every output against the model for the current inputs.
  task automatic check_all();
    logic [3:0] ev;
    for (int p = 0; p < 4; p++) ev[p] = (exp_q[p].size() != 0);
    chk("out_valid", {28'd0, out_valid}, {28'd0, ev});
    chk("out_1", out_1, model_head(0));
    chk("out_2", out_2, model_head(1));
    chk("out_3", out_3, model_head(2));
    chk("out_4", out_4, model_head(3));
    chk("in_ready", {31'd0, in_ready}, {31'd0, (exp_q[op].size() < 2)});
  endtask

  // driver: apply inputs, check, clock once, advance the model.
  task automatic step(input logic v, input logic [1:0] o, input logic [W-1:0] d,
                      input logic [3:0] r, input logic rst);
    logic acc;
    in_valid  = v;
    op        = o;
    in_data   = d;
    out_ready = r;
    reset     = rst;
    #1;
    if (!rst) check_all();
    acc = v && (exp_q[o].size() < 2);
    @(posedge clk);
    if (rst) begin
      for (int p = 0; p < 4; p++) exp_q[p].delete();
    end else begin
      for (int p = 0; p < 4; p++)
        if (r[p] && exp_q[p].size() > 0) void'(exp_q[p].pop_front());
      if (acc) exp_q[o].push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    in_valid = 0; op = 0; in_data = 0; out_ready = 0; reset = 1;
    @(negedge clk);
    step(0, 2'b00, 0, 4'b0000, 1);
    step(0, 2'b00, 0, 4'b0000, 1);

    // Idle after reset
    step(0, 2'b00, 0, 4'b0000, 0);
    chk("rst_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    // Single push to port 3
    step(1, 2'b10, 32'hAAAA_0001, 4'b0000, 0);
    chk("p3_valid", {28'd0, out_valid}, 32'h4);
    chk("p3_data", out_3, 32'hAAAA_0001);
    chk("p3_other", out_1 | out_2 | out_4, 32'd0);

    // Fill port 1, then probe in_ready per op
    step(1, 2'b00, 32'h11, 4'b0000, 0);
    step(1, 2'b00, 32'h22, 4'b0000, 0);
    op = 2'b00; in_valid = 0; #1;
    chk("full_rdy_op0", {31'd0, in_ready}, 32'd0);
    op = 2'b01; #1;
    chk("full_rdy_op1", {31'd0, in_ready}, 32'd1);
    // Push attempt while full is refused
    step(1, 2'b00, 32'h33, 4'b0001, 0);
    chk("pop1_head", out_1, 32'h22);
    step(0, 2'b00, 0, 4'b0001, 0);
    chk("pop2_head", out_1, 32'h0);
    chk("pop2_valid", {31'd0, out_valid[0]}, 32'd0);
    step(0, 2'b00, 0, 4'b0100, 0);  // drain port 3

    // Streaming into port 2
    for (int k = 1; k <= 10; k++) step(1, 2'b01, k, 4'b0010, 0);
    chk("stream_last", out_2, 32'd10);
    step(0, 2'b01, 0, 4'b0010, 0);

    // Interleaved ports 1 and 4
    step(1, 2'b00, 5, 4'b0000, 0);
    step(1, 2'b11, 6, 4'b0000, 0);
    step(1, 2'b00, 7, 4'b0000, 0);
    step(1, 2'b11, 8, 4'b0000, 0);
    chk("il_p1", out_1, 32'd5);
    chk("il_p4", out_4, 32'd6);
    step(0, 2'b00, 0, 4'b1001, 0);
    chk("il_p1b", out_1, 32'd7);
    chk("il_p4b", out_4, 32'd8);
    step(0, 2'b00, 0, 4'b1001, 0);

    // Reset mid-operation
    step(1, 2'b01, 32'hB0, 4'b0000, 0);
    step(1, 2'b10, 32'hC0, 4'b0000, 0);
    step(1, 2'b01, 32'hB1, 4'b1111, 1);
    step(0, 2'b00, 0, 4'b0000, 0);
    chk("mid_rst_valid", {28'd0, out_valid}, 32'd0);

    // Random traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom,
           4'($urandom_range(0, 15)), ($urandom_range(0, 49) == 0));
    end
    step(0, 2'b00, 0, 4'b0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
